// File: rtl/trn_tx_rr_arbiter.sv
// rtl/trn_tx_rr_arbiter.sv - round-robin arbiter sharing the TRN transmit path among NUM_REQ sources
// Grants one source until done/withdraw or hold timeout, with a one-cycle release gap.
module trn_tx_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 11,
  parameter int MAX_HOLD = 1024
) (
  input  logic               trn_clk,
  input  logic               reset_n,
  input  logic               trn_lnk_up_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_id,
  output logic               busy,
  output logic               timeout,
  output logic [7:0]         timeout_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   grant_id_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic               timeout_nxt;
  logic [7:0]         timeout_cnt_nxt;

  logic [IDX_W-1:0]   winner;
  logic               found;
  int                 best_off;
  int                 off;
  logic               owner_done;
  logic               owner_req;

  // Winner is the requester at the smallest rotational distance past the last winner.
  always_comb begin
    winner   = grant_id;
    best_off = NUM_REQ;
    off      = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j]) begin
        off = (j + 2 * NUM_REQ - 1 - int'(grant_id)) % NUM_REQ;
        if (off < best_off) begin
          best_off = off;
          winner   = IDX_W'(j);
        end
      end
    end
    found = (req != '0);
  end

  // grant is one-hot on grant_id while in GRANT, so masking avoids a variable index.
  assign owner_done = |(done & grant);
  assign owner_req  = |(req & grant);

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    grant_id_nxt    = grant_id;
    hold_cnt_nxt    = hold_cnt;
    timeout_nxt     = 1'b0;
    timeout_cnt_nxt = timeout_cnt;
    if (trn_lnk_up_n) begin
      state_nxt    = ST_IDLE;
      grant_nxt    = '0;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state_nxt    = ST_GRANT;
            grant_nxt    = NUM_REQ'(1) << winner;
            grant_id_nxt = winner;
            hold_cnt_nxt = '0;
          end
        end
        ST_GRANT: begin
          if (owner_done || !owner_req) begin
            state_nxt = ST_RELEASE;
            grant_nxt = '0;
          end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            state_nxt   = ST_RELEASE;
            grant_nxt   = '0;
            timeout_nxt = 1'b1;
            if (timeout_cnt != 8'hff) timeout_cnt_nxt = timeout_cnt + 8'd1;
          end else if (hold_cnt != '1) begin
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: state_nxt = ST_IDLE;
        default: begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_id    <= IDX_W'(NUM_REQ - 1);
      hold_cnt    <= '0;
      timeout     <= 1'b0;
      timeout_cnt <= 8'd0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_id    <= grant_id_nxt;
      hold_cnt    <= hold_cnt_nxt;
      timeout     <= timeout_nxt;
      timeout_cnt <= timeout_cnt_nxt;
    end
  end

  assign busy = |grant;

endmodule
